// File: rtl/div32_iter.sv
// Iterative 32-bit restoring divider (DIV/DIVU), one quotient bit per clock.
// Macro DIV32_SIGNED_EN builds signed operand conversion and result sign fix-up.
module div32_iter (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
    // Returns {cout, sum}.
    function automatic logic [32:0] cla32(input logic [31:0] x, input logic [31:0] y,
                                          input logic cin);
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] c;
        logic [8:0]  gc;
        logic        gg;
        logic        gp;
        g     = x & y;
        p     = x ^ y;
        c     = 32'd0;
        gc    = 9'd0;
        gc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
            gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = &p[4*k +: 4];
            gc[k+1] = gg | (gp & gc[k]);
        end
        return {gc[8], p ^ c};
    endfunction

`ifdef DIV32_SIGNED_EN
    function automatic logic [31:0] negate32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction
`endif

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] part_rem_q, part_rem_d;
    logic [31:0] quo_shift_q, quo_shift_d;
    logic [31:0] divisor_q, divisor_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;

    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] r_shift_s;
    logic        ovf_s;
    logic [32:0] sum_cout_s;
    logic [31:0] diff_s;
    logic        cout_s;

`ifdef DIV32_SIGNED_EN
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        b_zero_s;
`else
    logic        unused_signed_s;
    assign unused_signed_s = Signed;
`endif

    // Trial subtraction R' - B as R' + ~B + 1; the bit shifted out of R is the 33rd bit.
    assign r_shift_s  = {part_rem_q[30:0], quo_shift_q[31]};
    assign ovf_s      = part_rem_q[31];
    assign sum_cout_s = cla32(r_shift_s, ~divisor_q, 1'b1);
    assign diff_s     = sum_cout_s[31:0];
    assign cout_s     = sum_cout_s[32];

    // Operand magnitudes presented for capture at Start.
    always_comb begin
        a_mag_s = A;
        b_mag_s = B;
`ifdef DIV32_SIGNED_EN
        b_zero_s = (B == 32'd0);
        a_neg_s  = Signed & A[31];
        b_neg_s  = Signed & B[31];
        // On divide-by-zero the raw dividend is kept so the remainder returns A unchanged.
        if (a_neg_s && !b_zero_s) begin
            a_mag_s = negate32(A);
        end else begin
            a_mag_s = A;
        end
        if (b_neg_s) begin
            b_mag_s = negate32(B);
        end else begin
            b_mag_s = B;
        end
`endif
    end

    // Next-state and datapath control for IDLE/RUN/FIN.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        part_rem_d  = part_rem_q;
        quo_shift_d = quo_shift_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
`ifdef DIV32_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    quo_shift_d = a_mag_s;
                    divisor_d   = b_mag_s;
                    part_rem_d  = 32'd0;
                    cnt_d       = 5'd0;
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
`ifdef DIV32_SIGNED_EN
                    neg_quo_d   = (a_neg_s ^ b_neg_s) & ~b_zero_s;
                    neg_rem_d   = a_neg_s & ~b_zero_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ovf_s || cout_s) begin
                    part_rem_d  = diff_s;
                    quo_shift_d = {quo_shift_q[30:0], 1'b1};
                end else begin
                    part_rem_d  = r_shift_s;
                    quo_shift_d = {quo_shift_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN: begin
`ifdef DIV32_SIGNED_EN
                if (neg_quo_q) begin
                    quot_d = negate32(quo_shift_q);
                end else begin
                    quot_d = quo_shift_q;
                end
                if (neg_rem_q) begin
                    rem_d = negate32(part_rem_q);
                end else begin
                    rem_d = part_rem_q;
                end
`else
                quot_d = quo_shift_q;
                rem_d  = part_rem_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any operation in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            part_rem_q  <= 32'd0;
            quo_shift_q <= 32'd0;
            divisor_q   <= 32'd0;
            cnt_q       <= 5'd0;
            quot_q      <= 32'd0;
            rem_q       <= 32'd0;
`ifdef DIV32_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            part_rem_q  <= part_rem_d;
            quo_shift_q <= quo_shift_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
`ifdef DIV32_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;

endmodule

// File: doc/div32_iter.md
# div32_iter

Sequential 32-bit iterative divider for the CPU's DIV/DIVU path. It computes Quotient and Remainder of A / B by restoring division, one quotient bit per clock. It sits beside the ALU, and the execute stage stalls on Busy. Each trial subtraction reuses the team's 32-bit carry-lookahead adder, CLA32, with the divisor inverted and Cin = 1.

## Interface
Parameters:
- none. Width is fixed at 32.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  reset; asynchronous, active-low
- Start  input  1  request a division; sampled only in IDLE
- Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start
- A  input  32  dividend; sampled with Start
- B  input  32  divisor; sampled with Start
- Busy  output  1  operation in progress; reset 0
- Done  output  1  one-cycle pulse when results update; reset 0
- Quotient  output  32  result register; reset 0; holds until the next Done
- Remainder  output  32  result register; reset 0; holds until the next Done

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - On a Clk edge with Start=1, capture |A|, |B|, and sign flags (magnitudes only when signed mode is active).
  - Clear the partial remainder R (32 bits) and the 5-bit iteration counter.
  - Set Busy=1 and move to RUN.
- RUN, per edge:
  - Shift {R, Q} left by 1; the dividend MSB enters R, and the bit shifted out of R is kept as Ovf.
  - Compute D = R' + ~B + 1 using CLA32.
  - If Ovf | Cout, then R ← D and the new Q LSB = 1. Otherwise R is kept and the Q LSB = 0.
  - Increment the counter. After the 32nd iteration, go to FIN.
- FIN, one edge:
  - Apply sign correction and load Quotient/Remainder.
  - Set Done=1 and Busy=0, then return to IDLE.
- Sign rules (signed mode):
  - Quotient is negated if the signs of A and B differ.
  - Remainder takes the sign of A.
  - 0x80000000 / 0xFFFFFFFF yields Q=0x80000000, R=0.
- Divide by zero (B=0), both modes:
  - Q=0xFFFFFFFF and R=A, falling out naturally from the algorithm.
  - In signed mode, sign fix-up is suppressed so R equals the original A.
  - Same latency as a normal divide.
- Start while Busy=1 is ignored. A, B and Signed may change freely after capture.

## Timing
- Edge E0 captures Start. Busy=1 from after E0 until E33.
- Iterations run on edges E1..E32. FIN executes at E33.
- Done=1 for exactly the cycle after E33, and Busy=0 in that same cycle.
- Latency is 33 clocks from the Start edge to Done, independent of operands.
- Back-to-back: Start=1 during the Done cycle is accepted, so a new result arrives 33 clocks later.
- Reset asserted mid-operation:
  - Immediately: state=IDLE, Busy=0, Done=0, Quotient=0, Remainder=0.
  - The operation in flight is discarded, and no Done follows.
- Reset deassertion is synchronized by the system. The first Start is accepted on the first edge after release.

## Configuration
- Macro DIV32_SIGNED_EN.
- Defined: the Signed port is honored; magnitude conversion and sign fix-up logic are built.
- Undefined:
  - The Signed input is ignored, and every operation is treated as unsigned.
  - No negation logic is instantiated.
  - Latency and all other behavior are unchanged.

## Test plan
- Unsigned 100 / 7 (Signed=0) -> Done exactly 33 clocks after Start; Q=14, R=2; Busy high for 33 cycles.
- Unsigned 0xFFFFFFFF / 1 -> Q=0xFFFFFFFF, R=0. Then 5 / 0 -> Q=0xFFFFFFFF, R=5.
- With DIV32_SIGNED_EN, signed -7 / 2 (A=0xFFFFFFF9) -> Q=0xFFFFFFFD, R=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0.
- Without the macro, A=0xFFFFFFF9, B=2, Signed=1 -> unsigned result Q=0x7FFFFFFC, R=1.
- Start pulsed again at E5 with different operands -> ignored; the first result is unchanged. Start held through Done -> second operation begins, next Done 33 clocks later.
- Rst_n low at E10 of an operation -> all outputs 0 asynchronously. No Done within 40 cycles after release. A new 100 / 7 completes normally.
